// File: rtl/alu_acc_ctrl_pkg.sv
// Shared definitions for the accumulator command sequencer: command opcodes,
// ALU function codes, FSM state encoding and the decoded-opcode record.
package alu_acc_ctrl_pkg;

  // Command opcodes (4-bit). Codes 11..15 are illegal.
  localparam logic [3:0] OP_LOAD = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_ANDN = 4'd4;
  localparam logic [3:0] OP_ORN  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_ADC  = 4'd8;
  localparam logic [3:0] OP_CLR  = 4'd9;
  localparam logic [3:0] OP_READ = 4'd10;

  // Function select codes of the external combinational ALU.
  localparam logic [2:0] F_AND  = 3'b000;
  localparam logic [2:0] F_OR   = 3'b001;
  localparam logic [2:0] F_ADD  = 3'b010;
  localparam logic [2:0] F_ZERO = 3'b011;
  localparam logic [2:0] F_ANDN = 3'b100;
  localparam logic [2:0] F_ORN  = 3'b101;
  localparam logic [2:0] F_SUB  = 3'b110;
  localparam logic [2:0] F_SLT  = 3'b111;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_EXEC2 = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Decoded view of one opcode.
  typedef struct packed {
    logic [2:0] f;            // ALU function for the first pass
    logic       uses_alu;     // accumulator takes the ALU result
    logic       writes_carry; // carry takes the ALU carry-out
    logic       is_two_pass;  // needs a second ALU pass (carry-in add)
    logic       illegal;      // opcode outside the defined set
  } op_dec_t;

endpackage

// File: rtl/alu_acc_ctrl_op_dec.sv
// Combinational opcode decoder: maps a command opcode to the ALU function
// and the per-opcode control flags used by the sequencer.
module alu_acc_ctrl_op_dec
  import alu_acc_ctrl_pkg::*;
(
  input  logic [3:0] i_op,
  output op_dec_t    o_dec
);

  // Opcode lookup; LOAD/CLR/READ are legal but do not touch the ALU.
  always_comb begin
    o_dec   = '0;
    o_dec.f = F_ZERO;
    case (i_op)
      OP_LOAD, OP_CLR, OP_READ: begin
        o_dec.f = F_ZERO;
      end
      OP_AND: begin
        o_dec.f        = F_AND;
        o_dec.uses_alu = 1'b1;
      end
      OP_OR: begin
        o_dec.f        = F_OR;
        o_dec.uses_alu = 1'b1;
      end
      OP_ADD: begin
        o_dec.f            = F_ADD;
        o_dec.uses_alu     = 1'b1;
        o_dec.writes_carry = 1'b1;
      end
      OP_ANDN: begin
        o_dec.f        = F_ANDN;
        o_dec.uses_alu = 1'b1;
      end
      OP_ORN: begin
        o_dec.f        = F_ORN;
        o_dec.uses_alu = 1'b1;
      end
      OP_SUB: begin
        o_dec.f        = F_SUB;
        o_dec.uses_alu = 1'b1;
      end
      OP_SLT: begin
        o_dec.f        = F_SLT;
        o_dec.uses_alu = 1'b1;
      end
      OP_ADC: begin
        o_dec.f            = F_ADD;
        o_dec.uses_alu     = 1'b1;
        o_dec.writes_carry = 1'b1;
        o_dec.is_two_pass  = 1'b1;
      end
      default: begin
        o_dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_acc_ctrl.sv
// Accumulator command sequencer. Accepts one command, runs it through an
// external combinational ALU in one or two passes, updates the accumulator
// and carry, then holds a response until the consumer takes it.
//
// Handshakes: both the command and the response channel transfer on a rising
// clock edge where valid and ready are both high. The command source must
// hold i_cmd_valid/op/data until that edge; o_res_* are held stable from the
// rise of o_res_valid until the edge where i_res_ready is also high.
module alu_acc_ctrl
  import alu_acc_ctrl_pkg::*;
#(
  parameter int BW_DATA = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [3:0]         i_cmd_op,
  input  logic [BW_DATA-1:0] i_cmd_data,
  output logic               o_res_valid,
  input  logic               i_res_ready,
  output logic [BW_DATA-1:0] o_res_data,
  output logic               o_res_cout,
  output logic               o_res_zero,
  output logic               o_res_err,
  output logic [BW_DATA-1:0] o_alu_A,
  output logic [BW_DATA-1:0] o_alu_B,
  output logic [2:0]         o_alu_F,
  input  logic [BW_DATA-1:0] i_alu_Y,
  input  logic               i_alu_Cout
);

  state_e               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [BW_DATA-1:0]   data_q, data_d;
  logic [BW_DATA-1:0]   acc_q, acc_d;
  logic                 carry_q, carry_d;
  logic                 err_q, err_d;
  logic [BW_DATA-1:0]   tmp_q, tmp_d;
  logic                 c1_q, c1_d;
  logic                 res_valid_q, res_valid_d;

  op_dec_t dec;

  alu_acc_ctrl_op_dec u_op_dec (
    .i_op  (op_q),
    .o_dec (dec)
  );

  // ALU drive: first pass is acc op data, second pass adds the old carry to
  // the partial sum; every other state parks the ALU on the idle code.
  always_comb begin
    o_alu_A = '0;
    o_alu_B = '0;
    o_alu_F = F_ZERO;
    case (state_q)
      ST_EXEC: begin
        if (dec.uses_alu) begin
          o_alu_A = acc_q;
          o_alu_B = data_q;
          o_alu_F = dec.f;
        end
      end
      ST_EXEC2: begin
        o_alu_A = tmp_q;
        o_alu_B = BW_DATA'(carry_q);
        o_alu_F = F_ADD;
      end
      default: begin
        o_alu_F = F_ZERO;
      end
    endcase
  end

  // Next-state and datapath update for the command sequencer.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    err_d       = err_q;
    tmp_d       = tmp_q;
    c1_d        = c1_q;
    res_valid_d = res_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          op_d    = i_cmd_op;
          data_d  = i_cmd_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (dec.illegal) begin
          // Illegal opcode leaves acc/carry alone and flags the response.
          err_d       = 1'b1;
          res_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (dec.is_two_pass) begin
          // ADC: keep the partial sum and its carry for the second pass.
          tmp_d   = i_alu_Y;
          c1_d    = i_alu_Cout;
          state_d = ST_EXEC2;
        end else begin
          err_d = 1'b0;
          if (dec.uses_alu) begin
            acc_d = i_alu_Y;
          end
          if (dec.writes_carry) begin
            carry_d = i_alu_Cout;
          end
          if (op_q == OP_LOAD) begin
            acc_d   = data_q;
            carry_d = 1'b0;
          end else if (op_q == OP_CLR) begin
            acc_d   = '0;
            carry_d = 1'b0;
          end
          res_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_EXEC2: begin
        // At most one of the two passes can carry out, so OR is exact.
        acc_d       = i_alu_Y;
        carry_d     = c1_q | i_alu_Cout;
        err_d       = 1'b0;
        res_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (i_res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      data_q      <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
      tmp_q       <= '0;
      c1_q        <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      err_q       <= err_d;
      tmp_q       <= tmp_d;
      c1_q        <= c1_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign o_cmd_ready = (state_q == ST_IDLE);
  assign o_res_valid = res_valid_q;
  assign o_res_data  = acc_q;
  assign o_res_cout  = carry_q;
  assign o_res_zero  = (acc_q == '0);
  assign o_res_err   = err_q;

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Bench for alu_acc_ctrl: behavioural ALU, accumulator reference model,
// expected-response queue with a response monitor, directed and random tests.
module tb_alu_acc_ctrl;
  import alu_acc_ctrl_pkg::*;

  localparam int BW   = 4;
  localparam int EW   = BW + 3;
  localparam int MASK = (1 << BW) - 1;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  logic          i_cmd_valid = 1'b0;
  logic          o_cmd_ready;
  logic [3:0]    i_cmd_op = 4'd0;
  logic [BW-1:0] i_cmd_data = '0;
  logic          o_res_valid;
  logic          i_res_ready = 1'b1;
  logic [BW-1:0] o_res_data;
  logic          o_res_cout;
  logic          o_res_zero;
  logic          o_res_err;
  logic [BW-1:0] o_alu_A;
  logic [BW-1:0] o_alu_B;
  logic [2:0]    o_alu_F;
  logic [BW-1:0] i_alu_Y;
  logic          i_alu_Cout;

  alu_acc_ctrl #(.BW_DATA(BW)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_op    (i_cmd_op),
    .i_cmd_data  (i_cmd_data),
    .o_res_valid (o_res_valid),
    .i_res_ready (i_res_ready),
    .o_res_data  (o_res_data),
    .o_res_cout  (o_res_cout),
    .o_res_zero  (o_res_zero),
    .o_res_err   (o_res_err),
    .o_alu_A     (o_alu_A),
    .o_alu_B     (o_alu_B),
    .o_alu_F     (o_alu_F),
    .i_alu_Y     (i_alu_Y),
    .i_alu_Cout  (i_alu_Cout)
  );

  // ---------------- external ALU model ----------------
  // Non-add functions return a data-dependent junk carry so a sequencer that
  // wrongly latches it is caught.
  logic [BW:0] alu_sum;
  always_comb begin
    alu_sum    = {1'b0, o_alu_A} + {1'b0, o_alu_B};
    i_alu_Y    = '0;
    i_alu_Cout = ^{o_alu_A, o_alu_B, 1'b1};
    case (o_alu_F)
      3'b000: i_alu_Y = o_alu_A & o_alu_B;
      3'b001: i_alu_Y = o_alu_A | o_alu_B;
      3'b010: begin i_alu_Y = alu_sum[BW-1:0]; i_alu_Cout = alu_sum[BW]; end
      3'b100: i_alu_Y = o_alu_A & ~o_alu_B;
      3'b101: i_alu_Y = o_alu_A | ~o_alu_B;
      3'b110: i_alu_Y = o_alu_A - o_alu_B;
      3'b111: i_alu_Y = (o_alu_A < o_alu_B) ? BW'(1) : BW'(0);
      default: i_alu_Y = '0;
    endcase
  end

  // ---------------- counters / check helper ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  int m_acc   = 0;
  int m_carry = 0;
  int m_err   = 0;
  logic [EW-1:0] exp_q[$];

  task automatic model_cmd(input logic [3:0] op, input logic [BW-1:0] d);
    int dv;
    int s;
    logic [EW-1:0] e;
    dv    = int'(d);
    m_err = 0;
    case (op)
      OP_LOAD: begin m_acc = dv; m_carry = 0; end
      OP_AND:  m_acc = m_acc & dv;
      OP_OR:   m_acc = m_acc | dv;
      OP_ADD:  begin s = m_acc + dv; m_acc = s & MASK; m_carry = s >> BW; end
      OP_ANDN: m_acc = m_acc & (~dv & MASK);
      OP_ORN:  m_acc = (m_acc | ~dv) & MASK;
      OP_SUB:  m_acc = (m_acc - dv) & MASK;
      OP_SLT:  m_acc = (m_acc < dv) ? 1 : 0;
      OP_ADC:  begin s = m_acc + dv + m_carry; m_acc = s & MASK; m_carry = s >> BW; end
      OP_CLR:  begin m_acc = 0; m_carry = 0; end
      OP_READ: m_acc = m_acc;
      default: m_err = 1;
    endcase
    e[BW-1:0] = m_acc[BW-1:0];
    e[BW]     = m_carry[0];
    e[BW+1]   = (m_acc == 0);
    e[BW+2]   = m_err[0];
    exp_q.push_back(e);
  endtask

  // Response monitor: compares each accepted response against the queue.
  always @(negedge i_clk) begin
    if (!i_rst && o_res_valid && i_res_ready) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 32'(o_res_data), 32'hDEAD);
      end else begin
        chk("resp", 32'({o_res_err, o_res_zero, o_res_cout, o_res_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  // Response-ready driver: 0 = hold low, 1 = always high, 2 = random.
  int ready_mode = 1;
  always @(posedge i_clk) begin
    #1;
    if (ready_mode == 0)      i_res_ready = 1'b0;
    else if (ready_mode == 1) i_res_ready = 1'b1;
    else                      i_res_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] op, input logic [BW-1:0] d, input bit push);
    bit ok;
    ok = 1'b0;
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_data  = d;
    for (int k = 0; k < 80; k++) begin
      @(negedge i_clk);
      if (o_cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge i_clk);
      if (push) model_cmd(op, d);
    end else begin
      chk("cmd_accept_timeout", 32'(ok), 32'd1);
    end
    #1;
    i_cmd_valid = 1'b0;
  endtask

  // Sends one command and measures cycles from handshake to o_res_valid.
  task automatic send_lat(input logic [3:0] op, input logic [BW-1:0] d, input int exp_lat);
    int n;
    logic old_c;
    old_c = m_carry[0];
    n = 0;
    send(op, d, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge i_clk);
      if (op == OP_ADC && k == 2) begin
        chk("exec2_F", 32'(o_alu_F), 32'(F_ADD));
        chk("exec2_B", 32'(o_alu_B), 32'(old_c));
      end
      if (o_res_valid) begin
        n = k;
        break;
      end
    end
    chk("latency", 32'(n - 1), 32'(exp_lat));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #2;
    chk("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(o_res_valid), 32'd0);
    chk("rst_alu_A", 32'(o_alu_A), 32'd0);
    chk("rst_alu_B", 32'(o_alu_B), 32'd0);
    chk("rst_alu_F", 32'(o_alu_F), 32'(F_ZERO));
    chk("rst_state", 32'({o_res_err, o_res_zero, o_res_cout, o_res_data}), 32'h20);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;

    // LOAD 5, ADD 12 -> 1 with carry.
    send(OP_LOAD, 4'd5, 1'b1);
    send_lat(OP_ADD, 4'd12, 1);

    // CLR path, then overflow into ADC with carry-in.
    send(OP_LOAD, 4'd0, 1'b1);
    send(OP_ADD, 4'd1, 1'b1);
    send(OP_CLR, 4'd7, 1'b1);
    send(OP_LOAD, 4'd15, 1'b1);
    send(OP_ADD, 4'd1, 1'b1);
    send_lat(OP_ADC, 4'd15, 2);

    // SUB wrap and unsigned SLT.
    send(OP_LOAD, 4'd3, 1'b1);
    send(OP_SUB, 4'd5, 1'b1);
    send(OP_SLT, 4'd7, 1'b1);
    send(OP_LOAD, 4'd3, 1'b1);
    send(OP_SLT, 4'd7, 1'b1);

    // Response back-pressure with a waiting command.
    send(OP_LOAD, 4'd7, 1'b1);
    @(negedge i_clk);
    ready_mode = 0;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge i_clk);
        if (o_res_valid) begin seen = 1'b1; break; end
      end
      chk("stall_resp_seen", 32'(seen), 32'd1);
    end
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b1;
    i_cmd_op    = OP_READ;
    i_cmd_data  = 4'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      chk("stall_valid", 32'(o_res_valid), 32'd1);
      chk("stall_data", 32'(o_res_data), 32'd7);
      chk("stall_cmd_ready", 32'(o_cmd_ready), 32'd0);
    end
    ready_mode = 1;
    @(negedge i_clk);
    chk("resp_hs_cmd_ready", 32'(o_cmd_ready), 32'd0);
    @(negedge i_clk);
    chk("post_hs_cmd_ready", 32'(o_cmd_ready), 32'd1);
    chk("post_hs_res_valid", 32'(o_res_valid), 32'd0);
    @(posedge i_clk);
    model_cmd(OP_READ, 4'd0);
    #1;
    i_cmd_valid = 1'b0;
    chk("read_taken", 32'(o_cmd_ready), 32'd0);

    // Illegal opcode keeps acc/carry; READ clears err.
    send(OP_LOAD, 4'd15, 1'b1);
    send(OP_ADD, 4'd10, 1'b1);
    send(4'hF, 4'd3, 1'b1);
    send(OP_READ, 4'd0, 1'b1);

    // Asynchronous reset in the middle of an ADC second pass.
    send(OP_LOAD, 4'd15, 1'b1);
    send(OP_ADD, 4'd1, 1'b1);
    send(OP_ADC, 4'd3, 1'b0);
    @(posedge i_clk);
    #2;
    chk("abort_exec2_F", 32'(o_alu_F), 32'(F_ADD));
    chk("abort_exec2_B", 32'(o_alu_B), 32'd1);
    i_rst = 1'b1;
    #1;
    chk("abort_res_valid", 32'(o_res_valid), 32'd0);
    chk("abort_cmd_ready", 32'(o_cmd_ready), 32'd1);
    chk("abort_alu", 32'({o_alu_A, o_alu_B, o_alu_F}), 32'(F_ZERO));
    m_acc   = 0;
    m_carry = 0;
    m_err   = 0;
    @(negedge i_clk);
    i_rst = 1'b0;
    send(OP_READ, 4'd0, 1'b1);

    // Random commands with random response back-pressure.
    ready_mode = 2;
    for (int i = 0; i < 150; i++) begin
      send(4'($urandom_range(0, 15)), BW'($urandom_range(0, MASK)), 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge i_clk);
    end
    @(negedge i_clk);
    ready_mode = 1;
    for (int k = 0; k < 50; k++) begin
      @(negedge i_clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
